// File: rtl/ddr2_cmd_scheduler.sv
// ddr2_cmd_scheduler: one-request-at-a-time DDR2 command scheduler with per-bank timing and periodic refresh
module ddr2_cmd_scheduler #(
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RAS  = 9,
  parameter int T_RC   = 12,
  parameter int T_RRD  = 2,
  parameter int T_WR   = 3,
  parameter int T_RFC  = 26,
  parameter int T_REFI = 1560
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_bank,
  input  logic [13:0] req_row,
  input  logic [9:0]  req_col,
  output logic [2:0]  cmd,
  output logic [2:0]  cmd_bank,
  output logic [13:0] cmd_addr,
  output logic        done,
  output logic        ref_busy
);
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101;
  localparam logic [2:0] C_WR = 3'b100, C_PRE = 3'b010, C_REF = 3'b001;
  typedef enum logic [2:0] {IDLE, PRE, ACT, RW, REF_PRE, REF, REF_WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] open_q, open_d;
  logic [7:0][13:0] orow_q, orow_d;
  logic [7:0][5:0] act_cnt_q, act_cnt_d, pre_cnt_q, pre_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [5:0] gact_q, gact_d, rfc_q, rfc_d;
  logic [10:0] refi_q, refi_d;
  logic ref_pending_q, ref_pending_d;
  logic wr_q, wr_d;
  logic [2:0] bank_q, bank_d;
  logic [13:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic [2:0] cmd_q, cmd_d, cmd_bank_q, cmd_bank_d;
  logic [13:0] cmd_addr_q, cmd_addr_d;
  logic done_q, done_d, ready_q, ready_d, busy_q, busy_d;
  logic ras_all, rp_all, ref_issue;
  // A counter holding c at an edge means c+1 cycles have elapsed since its command issued.
  function automatic logic met(input logic [5:0] c, input int t);
    return int'(c) + 1 >= t;
  endfunction
  function automatic logic [5:0] sat(input logic [5:0] c);
    return c == 6'd63 ? c : c + 6'd1;
  endfunction
  always_comb begin
    state_d = state_q;
    open_d = open_q;
    orow_d = orow_q;
    wr_d = wr_q;
    bank_d = bank_q;
    row_d = row_q;
    col_d = col_q;
    cmd_d = C_NOP;
    cmd_bank_d = '0;
    cmd_addr_d = '0;
    done_d = 1'b0;
    ref_issue = 1'b0;
    ras_all = 1'b1;
    rp_all = 1'b1;
    gact_d = sat(gact_q);
    rfc_d = sat(rfc_q);
    for (int i = 0; i < 8; i++) begin
      act_cnt_d[i] = sat(act_cnt_q[i]);
      pre_cnt_d[i] = sat(pre_cnt_q[i]);
      wr_cnt_d[i] = sat(wr_cnt_q[i]);
      ras_all &= !open_q[i] || (met(act_cnt_q[i], T_RAS) && met(wr_cnt_q[i], T_WR));
      rp_all &= met(pre_cnt_q[i], T_RP);
    end
    case (state_q)
      IDLE:
        if (ref_pending_q) state_d = |open_q ? REF_PRE : REF;
        else if (req_valid && ready_q) begin
          wr_d = req_wr;
          bank_d = req_bank;
          row_d = req_row;
          col_d = req_col;
          state_d = !open_q[req_bank] ? ACT : orow_q[req_bank] == req_row ? RW : PRE;
        end
      PRE:
        if (met(act_cnt_q[bank_q], T_RAS) && met(wr_cnt_q[bank_q], T_WR)) begin
          cmd_d = C_PRE;
          cmd_bank_d = bank_q;
          open_d[bank_q] = 1'b0;
          pre_cnt_d[bank_q] = '0;
          state_d = ACT;
        end
      ACT:
        if (met(pre_cnt_q[bank_q], T_RP) && met(act_cnt_q[bank_q], T_RC) && met(gact_q, T_RRD)) begin
          cmd_d = C_ACT;
          cmd_bank_d = bank_q;
          cmd_addr_d = row_q;
          open_d[bank_q] = 1'b1;
          orow_d[bank_q] = row_q;
          act_cnt_d[bank_q] = '0;
          gact_d = '0;
          state_d = RW;
        end
      RW:
        if (met(act_cnt_q[bank_q], T_RCD)) begin
          cmd_d = wr_q ? C_WR : C_RD;
          cmd_bank_d = bank_q;
          cmd_addr_d = {4'b0, col_q};
          done_d = 1'b1;
          if (wr_q) wr_cnt_d[bank_q] = '0;
          state_d = IDLE;
        end
      REF_PRE:
        if (ras_all) begin
          cmd_d = C_PRE;
          cmd_addr_d = 14'h0400;
          open_d = '0;
          pre_cnt_d = '0;
          state_d = REF;
        end
      REF:
        if (rp_all) begin
          cmd_d = C_REF;
          ref_issue = 1'b1;
          rfc_d = '0;
          state_d = REF_WAIT;
        end
      REF_WAIT: if (int'(rfc_q) == T_RFC - 1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    refi_d = refi_q == 11'(T_REFI - 1) ? '0 : refi_q + 11'd1;
    ref_pending_d = refi_q == 11'(T_REFI - 1) || (ref_pending_q && !ref_issue);
    ready_d = state_d == IDLE && !ref_pending_d;
    busy_d = state_d inside {REF_PRE, REF, REF_WAIT};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      open_q <= '0;
      orow_q <= '0;
      act_cnt_q <= '1;
      pre_cnt_q <= '1;
      wr_cnt_q <= '1;
      gact_q <= '1;
      rfc_q <= '1;
      refi_q <= '0;
      ref_pending_q <= 1'b0;
      wr_q <= 1'b0;
      bank_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cmd_q <= C_NOP;
      cmd_bank_q <= '0;
      cmd_addr_q <= '0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      open_q <= open_d;
      orow_q <= orow_d;
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      gact_q <= gact_d;
      rfc_q <= rfc_d;
      refi_q <= refi_d;
      ref_pending_q <= ref_pending_d;
      wr_q <= wr_d;
      bank_q <= bank_d;
      row_q <= row_d;
      col_q <= col_d;
      cmd_q <= cmd_d;
      cmd_bank_q <= cmd_bank_d;
      cmd_addr_q <= cmd_addr_d;
      done_q <= done_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
  assign req_ready = ready_q;
  assign cmd = cmd_q;
  assign cmd_bank = cmd_bank_q;
  assign cmd_addr = cmd_addr_q;
  assign done = done_q;
  assign ref_busy = busy_q;
endmodule

// File: doc/ddr2_cmd_scheduler.md
DDR2_CMD_SCHEDULER -- requirements
Module: ddr2_cmd_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), all in clock cycles at tCK = 5 ns:
  T_RCD 3 (ACT to RD/WR); T_RP 3 (PRE to ACT/REF); T_RAS 9 (ACT to PRE); T_RC 12 (ACT to ACT, same bank); T_RRD 2 (ACT to ACT, any bank); T_WR 3 (WR to PRE); T_RFC 26 (REF to next command); T_REFI 1560 (refresh interval).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted when valid & ready
  req_wr  in  1  1 = write, 0 = read
  req_bank  in  3  bank
  req_row  in  14  row
  req_col  in  10  column
  cmd  out  3  NOP 111, ACTIVE 011, READ 101, WRITE 100, PRECHARGE 010, REFRESH 001
  cmd_bank  out  3  command bank
  cmd_addr  out  14  row for ACTIVE; {4'b0, col} for RD/WR; bit 10 = all-banks flag for PRECHARGE
  done  out  1  one-cycle pulse in the cycle READ/WRITE issues
  ref_busy  out  1  refresh sequence in progress
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The block SHALL hold, per bank, an open flag and a 14-bit open row, plus 6-bit saturating counters for cycles since ACTIVE, since PRECHARGE, and since WRITE. It SHALL also hold one global counter for cycles since the last ACTIVE to any bank.
REQ-005 Every counter SHALL clear to 0 on the cycle its command issues, increment each cycle after that, and saturate at 63.
REQ-006 FSM states SHALL be IDLE, PRE, ACT, RW, REF_PRE, REF and REF_WAIT. At most one command SHALL issue per cycle; cmd = NOP with cmd_bank = 0 and cmd_addr = 0 in every other cycle.
REQ-007 req_ready SHALL be 1 only in IDLE with ref_pending = 0. On acceptance the request SHALL be latched, and the FSM SHALL go to:
  RW if the bank is open with a matching row;
  PRE if the bank is open with a different row;
  ACT if the bank is closed.
REQ-008 PRE SHALL issue PRECHARGE (cmd_addr[10] = 0) once the bank's ACT counter >= T_RAS and its WR counter >= T_WR. It SHALL then clear the open flag and go to ACT.
REQ-009 ACT SHALL issue ACTIVE once all three hold: bank PRE counter >= T_RP, bank ACT counter >= T_RC, global ACT counter >= T_RRD. It SHALL then set open flag and row and go to RW.
REQ-010 RW SHALL issue READ or WRITE once the bank ACT counter >= T_RCD, pulse done in the same cycle, and go to IDLE.
REQ-011 Minimum latency from acceptance to the first command SHALL be 1 cycle. A closed-bank read with all counters saturated SHALL issue ACTIVE at acceptance+1 and READ at acceptance+1+T_RCD.
REQ-012 An 11-bit refresh counter SHALL count every cycle. When it reaches T_REFI-1 it SHALL wrap to 0 and set ref_pending. ref_pending SHALL clear when REFRESH issues. A further expiry while ref_pending is set SHALL leave it at 1, with no queuing.
REQ-013 From IDLE with ref_pending = 1, the FSM SHALL enter REF_PRE if any bank is open, otherwise REF. If req_valid and ref_pending are both 1 in the same cycle, refresh SHALL win and req_ready SHALL be 0. Refresh SHALL never interrupt a request already accepted.
REQ-014 REF_PRE SHALL issue one PRECHARGE with cmd_addr[10] = 1 once every open bank meets its T_RAS and T_WR counts. It SHALL then close all banks, clear all bank PRE counters and go to REF.
REQ-015 REF SHALL issue REFRESH once every bank PRE counter >= T_RP, then go to REF_WAIT. REF_WAIT SHALL hold for T_RFC cycles after REFRESH and then return to IDLE.
REQ-016 ref_busy SHALL be 1 in REF_PRE, REF and REF_WAIT, and 0 otherwise.

Reset
REQ-017 While rst_n = 0, all of the following SHALL hold immediately, without waiting for clk:
  FSM in IDLE; all banks closed; timing counters at 63; refresh counter and ref_pending at 0;
  cmd = 111; cmd_bank = 0; cmd_addr = 0; req_ready = 0; done = 0; ref_busy = 0.
REQ-018 req_ready SHALL first rise on the first clk edge after rst_n deasserts. Reset asserted mid-sequence SHALL abandon the sequence with no further commands.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - Read bank 2, row 0x0155, col 0x010, from reset -> ACTIVE (bank 2, addr 0x0155) at acceptance+1, READ (addr 0x0010) 3 cycles later, done high in that cycle.
  - Write bank 1, row 5, then read bank 1, row 5 -> second request gets READ at acceptance+1 with no ACTIVE.
  - Write bank 1, row 5, then read bank 1, row 6 immediately -> PRECHARGE no earlier than 9 cycles after ACTIVE and 3 after WRITE; ACTIVE row 6 3 cycles later; READ 3 cycles after that.
  - Back-to-back misses to banks 0 then 1 -> the two ACTIVEs are at least 2 cycles apart.
  - Idle 1560 cycles with bank 3 open -> PRECHARGE with addr[10] = 1, REFRESH 3 cycles later, req_ready low until 26 cycles after REFRESH.
  - req_valid held high, rst_n pulsed low between ACTIVE and READ -> cmd = 111 at once, no READ, and after release the same request re-issues ACTIVE.
